// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_e;
    localparam int FIFO_W = 16;
    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set req bit at or after rr_ptr (mod N).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int p;
            p = int'(rr_ptr) + k;
            if (p >= N) p -= N;
            if (req[p]) idx = p[IW-1:0];
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N producers.
// Define FIFO_ARB_STATS_EN to build saturating per-requester word counters on stats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = FIFO_W,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         din_bus,
    input  logic [N-1:0]           last,
    output logic [N-1:0]           ack,
    output logic                   fifo_wr,
    output logic [W-1:0]           fifo_din,
    input  logic                   fifo_full,
    input  logic                   fifo_over,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy,
    output logic                   err_over,
    output logic [N*STAT_W-1:0]    stats
);
    localparam int IW = $clog2(N);
    localparam logic [3:0] MB = 4'(MAX_BURST);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic          err_over_q, err_over_d;
    logic          pick_any, acc, rel;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            err_over_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            err_over_q <= err_over_d;
        end
    end

    always_comb begin
        acc        = (state_q == ARB_BURST) & req[grant_id_q] & ~fifo_full;
        // A dropped request releases the grant just like a final word.
        rel        = (acc & (last[grant_id_q] | (beat_cnt_q + 4'd1 == MB))) | ~req[grant_id_q];
        state_d    = (state_q == ARB_IDLE) ? ((pick_any & ~fifo_full) ? ARB_BURST : ARB_IDLE)
                                           : (rel ? ARB_IDLE : ARB_BURST);
        grant_id_d = (state_q == ARB_IDLE && pick_any && !fifo_full) ? pick_idx : grant_id_q;
        beat_cnt_d = (state_q == ARB_IDLE) ? 4'd0 : beat_cnt_q + {3'd0, acc};
        rr_ptr_d   = (state_q == ARB_BURST && rel)
                   ? ((grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1) : rr_ptr_q;
        err_over_d = err_over_q | fifo_over;
    end

    always_comb begin
        busy     = state_q == ARB_BURST;
        ack      = acc ? ({{(N-1){1'b0}}, 1'b1} << grant_id_q) : '0;
        fifo_wr  = acc;
        fifo_din = acc ? din_bus[grant_id_q*W +: W] : '0;
        grant_id = grant_id_q;
        err_over = err_over_q;
    end

`ifdef FIFO_ARB_STATS_EN
    logic [N*STAT_W-1:0] stats_q, stats_d;

    always_comb begin
        stats_d = stats_q;
        for (int i = 0; i < N; i++)
            stats_d[i*STAT_W +: STAT_W] = (ack[i] && stats_q[i*STAT_W +: STAT_W] != STAT_MAX)
                                        ? stats_q[i*STAT_W +: STAT_W] + 1'b1
                                        : stats_q[i*STAT_W +: STAT_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stats_q <= '0;
        else      stats_q <= stats_d;
    end

    assign stats = stats_q;
`else
    assign stats = '0;
`endif
endmodule
